// File: rtl/mips32_pkg.sv
// Shared definitions for the MIPS32 pipeline.
//   - Opcode constants of the instruction set (bits [31:26] of an instruction word).
//   - ifq_entry_t: instruction-fetch queue entry {ir, npc}.
//   - ifetch_state_e: fetch-unit FSM states.
package mips32_pkg;

    localparam logic [5:0] OpAdd   = 6'b000000;
    localparam logic [5:0] OpSub   = 6'b000001;
    localparam logic [5:0] OpAnd   = 6'b000010;
    localparam logic [5:0] OpOr    = 6'b000011;
    localparam logic [5:0] OpSlt   = 6'b000100;
    localparam logic [5:0] OpMul   = 6'b000101;
    localparam logic [5:0] OpLw    = 6'b001000;
    localparam logic [5:0] OpSw    = 6'b001001;
    localparam logic [5:0] OpAddi  = 6'b001010;
    localparam logic [5:0] OpSubi  = 6'b001011;
    localparam logic [5:0] OpSlti  = 6'b001100;
    localparam logic [5:0] OpBneqz = 6'b001101;
    localparam logic [5:0] OpBeqz  = 6'b001110;
    localparam logic [5:0] OpHlt   = 6'b111111;

    typedef struct packed {
        logic [31:0] ir;
        logic [31:0] npc;
    } ifq_entry_t;

    typedef enum logic [0:0] {
        StRun,
        StStop
    } ifetch_state_e;

    function automatic logic is_hlt(input logic [31:0] ir);
        return ir[31:26] == OpHlt;
    endfunction

endpackage

// File: rtl/mips32_ifetch_fifo.sv
// Generic synchronous FIFO with synchronous flush.
// Ports:
//   clk_i    clock
//   rst_ni   asynchronous active-low reset
//   flush_i  empty the FIFO (overrides push/pop in the same cycle)
//   push_i   write wdata_i (ignored when full unless a pop happens too)
//   wdata_i  write data
//   pop_i    remove the head (ignored when empty)
//   rdata_o  head entry (undefined when empty)
//   empty_o  no entries
//   count_o  number of entries, 0..Depth
// Depth must be a power of two so the pointers wrap naturally.
module mips32_ifetch_fifo #(
    parameter int unsigned Width = 32,
    parameter int unsigned Depth = 4
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           flush_i,
    input  logic                           push_i,
    input  logic [Width-1:0]               wdata_i,
    input  logic                           pop_i,
    output logic [Width-1:0]               rdata_o,
    output logic                           empty_o,
    output logic [$clog2(Depth+1)-1:0]     count_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             full, do_push, do_pop;

    assign full    = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
            if (do_push && !do_pop) count_d = count_q + CntW'(1);
            if (!do_push && do_pop) count_d = count_q - CntW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; reads of an empty FIFO are masked by the user.
    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/mips32_ifetch_queue.sv
// MIPS32 instruction-fetch front end with an in-order prefetch queue.
// Issues word-addressed fetches, buffers returned words with their next-PC and hands them to ID
// over valid/ready. Fetch stops once a HLT word is returned and resumes only on a redirect.
// Ports:
//   clk1            pipeline clock
//   rst_n           asynchronous active-low reset
//   imem_req_valid  fetch request valid             imem_req_ready  memory accepts request
//   imem_req_addr   request word address (pc)
//   imem_rsp_valid  in-order response valid         imem_rsp_data   instruction word
//   redirect_valid  taken branch: flush + refetch   redirect_pc     branch target word address
//   id_valid        queue head valid                id_ready        ID consumes head
//   id_ir           head instruction                id_npc          head address + 1
//   halted          HLT fetched, no more requests
// Build option: define IFETCH_BYPASS_EN to forward a response straight to ID when the queue is
// empty (0-cycle latency); otherwise every word passes through the queue.
module mips32_ifetch_queue #(
    parameter int unsigned          ADDR_W   = 10,
    parameter int unsigned          DEPTH    = 4,
    parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
    input  logic              clk1,
    input  logic              rst_n,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [31:0]       imem_rsp_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [31:0]       id_ir,
    output logic [31:0]       id_npc,
    output logic              halted
);

    import mips32_pkg::*;

    localparam int unsigned    CntW     = $clog2(DEPTH + 1);
    localparam logic [CntW:0]  DepthOcc = (CntW + 1)'(DEPTH);

    ifetch_state_e     state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [CntW-1:0]   outst_q, outst_d, discard_q, discard_d;

    logic [CntW-1:0]   q_count, afifo_count;
    logic              q_empty, afifo_empty;
    logic [ADDR_W-1:0] rsp_addr;
    ifq_entry_t        rsp_entry, q_head, head;
    logic              req_hs, rsp_live, rsp_kept, bypass, deq;
    logic [CntW:0]     occ;

    assign occ = {1'b0, q_count} + {1'b0, outst_q};

    assign imem_req_valid = rst_n && (state_q == StRun) && !redirect_valid && (occ < DepthOcc);
    assign imem_req_addr  = pc_q;
    assign req_hs         = imem_req_valid && imem_req_ready;

    // A live response belongs to the current fetch stream and pops its address. In StStop it is
    // a word fetched past the HLT: its address is retired but the word is not queued.
    assign rsp_live = imem_rsp_valid && (discard_q == '0) && !redirect_valid;
    assign rsp_kept = rsp_live && (state_q == StRun);

    assign rsp_entry.ir  = imem_rsp_data;
    assign rsp_entry.npc = {{(32 - ADDR_W){1'b0}}, rsp_addr + ADDR_W'(1)};

`ifdef IFETCH_BYPASS_EN
    assign bypass = q_empty && rsp_kept;
`else
    assign bypass = 1'b0;
`endif

    assign head     = bypass ? rsp_entry : q_head;
    assign id_valid = bypass || !q_empty;
    assign id_ir    = id_valid ? head.ir : '0;
    assign id_npc   = id_valid ? head.npc : '0;
    assign deq      = id_valid && id_ready;
    assign halted   = (state_q == StStop);

    // Request addresses travel alongside the memory; stale ones are dropped by the flush and the
    // matching stale responses are skipped through discard_q without popping.
    mips32_ifetch_fifo #(
        .Width (ADDR_W),
        .Depth (DEPTH)
    ) u_addr_fifo (
        .clk_i   (clk1),
        .rst_ni  (rst_n),
        .flush_i (redirect_valid),
        .push_i  (req_hs),
        .wdata_i (pc_q),
        .pop_i   (rsp_live),
        .rdata_o (rsp_addr),
        .empty_o (afifo_empty),
        .count_o (afifo_count)
    );

    mips32_ifetch_fifo #(
        .Width ($bits(ifq_entry_t)),
        .Depth (DEPTH)
    ) u_instr_fifo (
        .clk_i   (clk1),
        .rst_ni  (rst_n),
        .flush_i (redirect_valid),
        .push_i  (rsp_kept && !(bypass && id_ready)),
        .wdata_i (rsp_entry),
        .pop_i   (deq && !bypass),
        .rdata_o (q_head),
        .empty_o (q_empty),
        .count_o (q_count)
    );

    logic unused_afifo;
    assign unused_afifo = ^{afifo_count, afifo_empty};

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        outst_d   = outst_q;
        discard_d = discard_q;

        if (req_hs) pc_d = pc_q + ADDR_W'(1);
        if (req_hs && !imem_rsp_valid) outst_d = outst_q + CntW'(1);
        if (!req_hs && imem_rsp_valid) outst_d = outst_q - CntW'(1);
        if (imem_rsp_valid && (discard_q != '0)) discard_d = discard_q - CntW'(1);

        unique case (state_q)
            StRun:   if (rsp_kept && is_hlt(imem_rsp_data)) state_d = StStop;
            StStop:  ;
            default: state_d = StRun;
        endcase

        // No request issues in a redirect cycle, so everything still in flight is stale.
        if (redirect_valid) begin
            pc_d      = redirect_pc;
            discard_d = outst_q - CntW'(imem_rsp_valid);
            state_d   = StRun;
        end
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StRun;
            pc_q      <= RESET_PC;
            outst_q   <= '0;
            discard_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            outst_q   <= outst_d;
            discard_q <= discard_d;
        end
    end

endmodule

// File: tb/tb_mips32_ifetch_queue.sv
module tb_mips32_ifetch_queue;

    localparam int unsigned ADDR_W = 10;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned MEM_N  = 1 << ADDR_W;
`ifdef IFETCH_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    logic              clk1 = 1'b0;
    logic              rst_n = 1'b0;
    logic              imem_req_valid, imem_req_ready;
    logic [ADDR_W-1:0] imem_req_addr;
    logic              imem_rsp_valid;
    logic [31:0]       imem_rsp_data;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              id_valid, id_ready;
    logic [31:0]       id_ir, id_npc;
    logic              halted;

    always #5 clk1 = ~clk1;

    mips32_ifetch_queue #(
        .ADDR_W   (ADDR_W),
        .DEPTH    (DEPTH),
        .RESET_PC ('0)
    ) dut (
        .clk1           (clk1),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_ir          (id_ir),
        .id_npc         (id_npc),
        .halted         (halted)
    );

    typedef struct {
        int unsigned gen;
        logic [31:0] ir;
        logic [31:0] npc;
    } exp_t;
    typedef struct {
        logic [31:0] data;
        int unsigned due;
    } pend_t;

    exp_t        exp_q[$];
    pend_t       pend_q[$];
    pend_t       p;
    logic [31:0] mem [MEM_N];
    int          checks = 0;
    int          failures = 0;
    int unsigned stim_gen = 0, mon_gen = 1, cyc = 0, lat = 1;
    bit          rdy_rand = 1'b0;
    int unsigned model_pc = 0, req_cnt = 0, dlv_cnt = 0;
    int unsigned r0, d0, tgt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
        end
    endtask

    // Model: after a redirect (or reset) to T, ID sees Mem[T], Mem[T+1], ... with npc = addr+1,
    // ending with the first HLT word.
    function automatic void push_stream(input int unsigned target);
        exp_t e;
        int unsigned a;
        stim_gen++;
        for (int i = 0; i < 200; i++) begin
            a     = (target + i) % MEM_N;
            e.gen = stim_gen;
            e.ir  = mem[a];
            e.npc = (a + 1) % MEM_N;
            exp_q.push_back(e);
            if (mem[a][31:26] == 6'h3F) break;
        end
    endfunction

    function automatic int unsigned remaining(input int unsigned g);
        int unsigned n = 0;
        foreach (exp_q[i]) if (exp_q[i].gen == g) n++;
        return n;
    endfunction

    task automatic cycles(input int n);
        repeat (n) @(posedge clk1);
        #1;
    endtask

    task automatic do_redirect(input int unsigned target);
        redirect_valid = 1'b1;
        redirect_pc    = ADDR_W'(target);
        push_stream(target);
        @(posedge clk1);
        #1;
        redirect_valid = 1'b0;
    endtask

    // Instruction memory: in-order responses, lat cycles after acceptance.
    initial begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        imem_req_ready = 1'b1;
        forever begin
            @(posedge clk1);
            #1;
            cyc++;
            if (!rst_n) begin
                pend_q.delete();
                imem_rsp_valid = 1'b0;
            end else if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = pend_q[0].data;
                void'(pend_q.pop_front());
            end else begin
                imem_rsp_valid = 1'b0;
                imem_rsp_data  = $urandom;
            end
            imem_req_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
            @(negedge clk1);
            if (rst_n && imem_req_valid && imem_req_ready) begin
                p.data = mem[imem_req_addr];
                p.due  = cyc + lat;
                pend_q.push_back(p);
            end
        end
    end

    // Monitor: request addresses and delivered words against the model.
    initial begin
        forever begin
            @(negedge clk1);
            if (rst_n) begin
                if (redirect_valid) check("req_valid_in_redirect", 32'(imem_req_valid), 0);
                if (halted) check("req_while_halted", 32'(imem_req_valid), 0);
                if (imem_req_valid && imem_req_ready) begin
                    check("req_addr", 32'(imem_req_addr), model_pc);
                    model_pc = (model_pc + 1) % MEM_N;
                    req_cnt++;
                end
                if (id_valid && id_ready) begin
                    while (exp_q.size() > 0 && exp_q[0].gen < mon_gen) void'(exp_q.pop_front());
                    if (exp_q.size() == 0 || exp_q[0].gen != mon_gen) begin
                        checks++;
                        failures++;
                        $display("FAIL id_extra_word: got ir 0x%08h npc 0x%08h, required none",
                                 id_ir, id_npc);
                    end else begin
                        check("id_ir", id_ir, exp_q[0].ir);
                        check("id_npc", id_npc, exp_q[0].npc);
                        void'(exp_q.pop_front());
                    end
                    dlv_cnt++;
                end
                if (redirect_valid) begin
                    mon_gen++;
                    model_pc = redirect_pc;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < MEM_N; i++) begin
            mem[i] = $urandom;
            if (mem[i][31:26] == 6'h3F) mem[i][31:26] = 6'h01;
        end
        id_ready       = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        push_stream(0);

        // Reset values.
        repeat (3) @(posedge clk1);
        @(negedge clk1);
        check("rst_req_valid", 32'(imem_req_valid), 0);
        check("rst_req_addr", 32'(imem_req_addr), 0);
        check("rst_id_valid", 32'(id_valid), 0);
        check("rst_id_ir", id_ir, 0);
        check("rst_id_npc", id_npc, 0);
        check("rst_halted", 32'(halted), 0);
        @(posedge clk1);
        #1;
        rst_n = 1'b1;
        @(negedge clk1);
        check("post_rst_req_valid", 32'(imem_req_valid), 1);
        check("post_rst_req_addr", 32'(imem_req_addr), 0);

        // Streaming from reset: one request and one instruction per cycle.
        cycles(5);
        r0 = req_cnt;
        d0 = dlv_cnt;
        cycles(10);
        check("req_rate", req_cnt - r0, 10);
        check("id_rate", dlv_cnt - d0, 10);

        // ID stalls: the queue fills with exactly DEPTH words, then drains in order.
        id_ready = 1'b0;
        do_redirect(32'h100);
        r0 = req_cnt;
        cycles(11);
        @(negedge clk1);
        check("stall_req_count", req_cnt - r0, DEPTH);
        check("stall_req_valid", 32'(imem_req_valid), 0);
        check("stall_id_valid", 32'(id_valid), 1);
        check("stall_head_npc", id_npc, 32'h101);
        @(posedge clk1);
        #1;
        id_ready = 1'b1;
        cycles(20);

        // Slow memory: three stale responses in flight when redirecting to 0x40.
        lat = 3;
        do_redirect(32'h200);
        cycles(3);
        d0 = dlv_cnt;
        do_redirect(32'h40);
        cycles(20);
        check("slow_mem_delivered", 32'(dlv_cnt - d0 >= 5), 1);

        // pc wraps modulo 2^ADDR_W.
        lat = 1;
        do_redirect(32'h3FE);
        cycles(2);
        @(negedge clk1);
        check("wrap_req_valid", 32'(imem_req_valid), 1);
        check("wrap_req_addr", 32'(imem_req_addr), 0);
        cycles(6);

        // Redirect coinciding with a dequeue and a response.
        do_redirect(32'h300);
        cycles(8);
        redirect_valid = 1'b1;
        redirect_pc    = ADDR_W'(32'h80);
        push_stream(32'h80);
        @(negedge clk1);
        check("coincide_setup", 32'({id_valid, id_ready, imem_rsp_valid}), 32'h7);
        @(posedge clk1);
        #1;
        redirect_valid = 1'b0;
        @(negedge clk1);
        check("flush_empty_next", 32'(id_valid), 0);
        @(negedge clk1);
        check("refill_latency", 32'(id_valid), 32'(BYP));
        @(negedge clk1);
        check("refill_valid", 32'(id_valid), 1);
        cycles(5);

        // HLT at address 5: words 0..5 delivered, then fetch stops until redirect.
        mem[5] = {6'h3F, 26'($urandom)};
        do_redirect(0);
        cycles(30);
        @(negedge clk1);
        check("hlt_halted", 32'(halted), 1);
        check("hlt_id_valid", 32'(id_valid), 0);
        check("hlt_req_valid", 32'(imem_req_valid), 0);
        check("hlt_words_left", remaining(mon_gen), 0);
        @(posedge clk1);
        #1;
        do_redirect(32'h10);
        @(negedge clk1);
        check("restart_halted", 32'(halted), 0);
        check("restart_req_valid", 32'(imem_req_valid), 1);
        check("restart_req_addr", 32'(imem_req_addr), 32'h10);
        cycles(20);

        // Randomized traffic: memory stalls, ID stalls, latency changes and redirects.
        rdy_rand = 1'b1;
        for (int c = 0; c < 400; c++) begin
            id_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 24) == 0) begin
                lat = $urandom_range(1, 4);
                tgt = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 6) : $urandom_range(0, MEM_N - 1);
                redirect_valid = 1'b1;
                redirect_pc    = ADDR_W'(tgt);
                push_stream(tgt);
            end else begin
                redirect_valid = 1'b0;
            end
            @(posedge clk1);
            #1;
        end
        redirect_valid = 1'b0;
        id_ready       = 1'b1;
        rdy_rand       = 1'b0;
        cycles(40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
